// File: rtl/syncram_pkg.sv
// syncram_pkg: shared types and constants for the syncram_clr RAM.
//   state_t     clear sequencer states (CLEAR, IDLE)
//   DEF_DATA_W  default word width
//   DEF_ADDR_W  default address width
//   RD_LAT      read latency in cycles; 2 when SYNCRAM_OUTREG_EN is defined, else 1
package syncram_pkg;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 8;

`ifdef SYNCRAM_OUTREG_EN
  localparam int unsigned RD_LAT = 2;
`else
  localparam int unsigned RD_LAT = 1;
`endif

endpackage

// File: rtl/syncram_clr_seq.sv
// syncram_clr_seq: post-reset clear sequencer for syncram_clr.
// Sweeps every word address 0..DEPTH-1, one per cycle, then parks in IDLE.
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset; restarts the sweep from word 0
//   busy      high while the sweep is in progress (registered)
//   clr_we    clear write enable for the RAM port
//   clr_addr  word address being cleared this cycle
module syncram_clr_seq
  import syncram_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      // busy drops on the edge that writes the last word, so the next
      // edge is already free for user accesses.
      if (cnt == LAST) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

  assign clr_we   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/syncram_clr.sv
// syncram_clr: synchronous single-port RAM with registered read, read-valid
// strobe, write-first read-during-write and a hardware clear after reset.
// Build option: define SYNCRAM_OUTREG_EN to add a second output register
// (read latency 2 instead of 1, throughput unchanged).
// Ports:
//   clk     clock, rising edge
//   rst     synchronous active-high reset
//   WE      write enable (ignored while busy)
//   RE      read enable (ignored while busy)
//   adress  word address shared by read and write
//   WD      write data
//   Q       read data; holds its value when no read completes
//   valid   one-cycle strobe marking fresh data on Q
//   busy    clear sweep in progress
module syncram_clr
  import syncram_pkg::*;
#(
  parameter int unsigned           DATA_W    = DEF_DATA_W,
  parameter int unsigned           ADDR_W    = DEF_ADDR_W,
  parameter int unsigned           DEPTH     = 2 ** ADDR_W,
  parameter logic [DATA_W-1:0]     CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WE,
  input  logic              RE,
  input  logic [ADDR_W-1:0] adress,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] Q,
  output logic              valid,
  output logic              busy
);

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              in_range;
  logic              rd_go;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] q_rd;
  logic              v_rd;

  syncram_clr_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign in_range = {1'b0, adress} < DEPTH_V;
  assign rd_go    = RE && !busy;

  // Single RAM write port: the clear sweep owns it while busy; memory is
  // left untouched whenever rst is high.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clr_addr;
    wr_data = CLEAR_VAL;
    if (!rst) begin
      if (clr_we) begin
        wr_en = 1'b1;
      end else if (WE && in_range) begin
        wr_en   = 1'b1;
        wr_addr = adress;
        wr_data = WD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Write-first: a same-cycle write forwards WD; out-of-range reads see CLEAR_VAL.
  always_comb begin
    rd_data = CLEAR_VAL;
    if (in_range) rd_data = WE ? WD : mem[adress];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_rd <= '0;
      v_rd <= 1'b0;
    end else begin
      v_rd <= rd_go;
      if (rd_go) q_rd <= rd_data;
    end
  end

`ifdef SYNCRAM_OUTREG_EN
  logic [DATA_W-1:0] q_out;
  logic              v_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_out <= '0;
      v_out <= 1'b0;
    end else begin
      q_out <= q_rd;
      v_out <= v_rd;
    end
  end

  assign Q     = q_out;
  assign valid = v_out;
`else
  assign Q     = q_rd;
  assign valid = v_rd;
`endif

endmodule
